intra_edge_filter_stream: RTL and testbench

//  Streaming, parametrised AV1 intra edge filter for one leftCol or aboveRow.

---
 rtl/intra_edge_filter_stream_pkg.sv | 22 ++
 rtl/intra_edge_filter_stream_if.sv | 30 +++
 rtl/intra_edge_filter_stream_tap5.sv | 27 ++
 rtl/intra_edge_filter_stream.sv | 129 ++++++++++++
 tb/tb_intra_edge_filter_stream.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/intra_edge_filter_stream_pkg.sv
// Shared types, kernel table and helpers for the streaming AV1 intra edge filter.
// Kernel rows are indexed by strength-1; every row sums to 16.
package intra_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILT,
        DONE
    } ief_state_t;

    localparam logic [3:0] INTRA_EDGE_KERNEL [3][5] = '{
        '{4'd0, 4'd4, 4'd8, 4'd4, 4'd0},
        '{4'd0, 4'd5, 4'd6, 4'd5, 4'd0},
        '{4'd2, 4'd4, 4'd4, 4'd4, 4'd2}
    };

    function automatic int clip3(input int lo, input int hi, input int x);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

endpackage

// File: rtl/intra_edge_filter_stream_if.sv
// Request/response stream bundle between edge fetch, the edge filter and the intra predictor.
interface intra_edge_filter_stream_if #(
    parameter int MAX_SIZE = 16,
    parameter int CH       = 3,
    parameter int BD       = 10
);
    localparam int NW = $clog2(MAX_SIZE + 1);

    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_strength;
    logic [NW-1:0]            in_num_px;
    logic [CH*BD-1:0]         in_ref;
    logic [MAX_SIZE*CH*BD-1:0] in_edge;
    logic                     out_valid;
    logic                     out_ready;
    logic [MAX_SIZE*CH*BD-1:0] out_edge;
    logic [NW-1:0]            out_num_px;

    modport master (
        output in_valid, in_strength, in_num_px, in_ref, in_edge, out_ready,
        input  in_ready, out_valid, out_edge, out_num_px
    );

    modport slave (
        input  in_valid, in_strength, in_num_px, in_ref, in_edge, out_ready,
        output in_ready, out_valid, out_edge, out_num_px
    );

endinterface

// File: rtl/intra_edge_filter_stream_tap5.sv
// One channel of the 5-tap edge kernel: weighted sum plus rounding, shifted down by 4.
// Strength 0 never reaches the output (bypass), so it simply aliases row 0.
module intra_edge_tap5
    import intra_pkg::*;
#(
    parameter int BD = 10
) (
    input  logic [BD-1:0] tap_i [5],
    input  logic [1:0]    strength_i,
    output logic [BD-1:0] result_o
);
    localparam int ACC_W = BD + 4;

    logic [1:0]       row;
    logic [ACC_W-1:0] acc;

    // Kernel rows sum to 16, so the rounded result always fits back into BD bits.
    always_comb begin
        row = (strength_i == 2'd0) ? 2'd0 : strength_i - 2'd1;
        acc = ACC_W'(8);
        for (int j = 0; j < 5; j++) begin
            acc = acc + ACC_W'(INTRA_EDGE_KERNEL[row][j]) * ACC_W'(tap_i[j]);
        end
        result_o = BD'(acc >> 4);
    end

endmodule

// File: rtl/intra_edge_filter_stream.sv
// Streaming AV1 intra edge filter for one leftCol/aboveRow: one sample position per cycle,
// all channels in parallel; e[] holds ref at index 0 followed by the captured edge.
//
//   state | meaning
//   IDLE  | ready for a new edge request
//   LOAD  | seed output with the input edge, pick bypass or filter
//   FILT  | filter position idx (1..num_px) into lane idx-1
//   DONE  | result valid, held until the consumer accepts
module intra_edge_filter_stream
    import intra_pkg::*;
#(
    parameter int MAX_SIZE = 16,
    parameter int CH       = 3,
    parameter int BD       = 10,
    parameter int TAPS     = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    intra_edge_filter_stream_if.slave  edge_if,
    output logic                       busy
);
    localparam int SW = CH * BD;
    localparam int NW = $clog2(MAX_SIZE + 1);

    if (TAPS != 5) begin : g_taps_check
        $fatal(1, "intra_edge_filter_stream: TAPS must be 5");
    end

    ief_state_t    state_q, state_d;
    logic [SW-1:0] e_q   [MAX_SIZE+1];
    logic [SW-1:0] e_d   [MAX_SIZE+1];
    logic [SW-1:0] out_q [MAX_SIZE];
    logic [SW-1:0] out_d [MAX_SIZE];
    logic [1:0]    str_q, str_d;
    logic [NW-1:0] npx_q, npx_d;
    logic [NW-1:0] idx_q, idx_d;
    logic [NW-1:0] npx_clamped;
    logic [SW-1:0] win [5];
    logic [SW-1:0] filt;

    assign npx_clamped = (int'(edge_if.in_num_px) > MAX_SIZE) ? NW'(MAX_SIZE) : edge_if.in_num_px;

    // Taps beyond either end of the edge replicate the end sample.
    always_comb begin
        for (int j = 0; j < 5; j++) begin
            win[j] = '0;
            for (int n = 0; n <= MAX_SIZE; n++) begin
                if (n == clip3(0, int'(npx_q), int'(idx_q) - 2 + j)) win[j] = e_q[n];
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [BD-1:0] tap [5];
        always_comb begin
            for (int j = 0; j < 5; j++) tap[j] = win[j][c*BD +: BD];
        end
        intra_edge_tap5 #(.BD(BD)) u_tap (
            .tap_i      (tap),
            .strength_i (str_q),
            .result_o   (filt[c*BD +: BD])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            e_q     <= '{default: '0};
            out_q   <= '{default: '0};
            str_q   <= '0;
            npx_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            out_q   <= out_d;
            str_q   <= str_d;
            npx_q   <= npx_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        out_d   = out_q;
        str_d   = str_q;
        npx_d   = npx_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (edge_if.in_valid) begin
                    e_d[0] = edge_if.in_ref;
                    for (int n = 0; n < MAX_SIZE; n++) e_d[n+1] = edge_if.in_edge[n*SW +: SW];
                    str_d   = edge_if.in_strength;
                    npx_d   = npx_clamped;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                for (int n = 0; n < MAX_SIZE; n++) out_d[n] = e_q[n+1];
                idx_d   = NW'(1);
                state_d = (str_q == 2'd0 || npx_q == '0) ? DONE : FILT;
            end
            FILT: begin
                for (int n = 0; n < MAX_SIZE; n++) begin
                    if (n == int'(idx_q) - 1) out_d[n] = filt;
                end
                if (idx_q == npx_q) state_d = DONE;
                else                idx_d   = idx_q + NW'(1);
            end
            DONE: begin
                if (edge_if.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        edge_if.out_edge = '0;
        for (int n = 0; n < MAX_SIZE; n++) edge_if.out_edge[n*SW +: SW] = out_q[n];
    end

    assign edge_if.in_ready   = (state_q == IDLE);
    assign edge_if.out_valid  = (state_q == DONE);
    assign edge_if.out_num_px = npx_q;
    assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_intra_edge_filter_stream.sv
// Directed bench for intra_edge_filter_stream with a reference model feeding a scoreboard queue.
module tb_intra_edge_filter_stream;
    localparam int MS = 16;
    localparam int CH = 3;
    localparam int BD = 10;
    localparam int SW = CH * BD;
    localparam int W  = MS * SW;
    localparam int NW = $clog2(MS + 1);

    typedef struct {
        logic [W-1:0] edge_v;
        int           npx;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    intra_edge_filter_stream_if #(.MAX_SIZE(MS), .CH(CH), .BD(BD)) bus ();

    intra_edge_filter_stream #(.MAX_SIZE(MS), .CH(CH), .BD(BD), .TAPS(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .edge_if (bus),
        .busy    (busy)
    );

    task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [SW-1:0] rf, input logic [W-1:0] ed,
                                           input int s, input int np);
        int           kt [3][5];
        logic [SW-1:0] e [MS+1];
        logic [W-1:0] o;
        int           acc;
        int           k;
        kt = '{'{0, 4, 8, 4, 0}, '{0, 5, 6, 5, 0}, '{2, 4, 4, 4, 2}};
        if (np > MS) np = MS;
        o    = ed;
        e[0] = rf;
        for (int n = 0; n < MS; n++) e[n+1] = ed[n*SW +: SW];
        if (s != 0 && np != 0) begin
            for (int i = 1; i <= np; i++) begin
                for (int c = 0; c < CH; c++) begin
                    acc = 8;
                    for (int j = 0; j < 5; j++) begin
                        k = i - 2 + j;
                        if (k < 0)  k = 0;
                        if (k > np) k = np;
                        acc += kt[s-1][j] * int'(e[k][c*BD +: BD]);
                    end
                    o[(i-1)*SW + c*BD +: BD] = BD'(acc >> 4);
                end
            end
        end
        return o;
    endfunction

    function automatic logic [W-1:0] rand_edge();
        logic [W-1:0] v;
        for (int n = 0; n < MS * CH; n++) v[n*BD +: BD] = BD'($urandom);
        return v;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic run_txn(input string tag, input int s, input int np, input logic [SW-1:0] rf,
                           input logic [W-1:0] ed, input int hold, output logic [W-1:0] got);
        exp_t x;
        int   lat;
        int   eff;
        eff      = (np > MS) ? MS : np;
        x.edge_v = model(rf, ed, s, np);
        x.npx    = eff;
        x.lat    = (s == 0 || eff == 0) ? 2 : eff + 2;
        sb.push_back(x);

        bus.in_valid    = 1'b1;
        bus.in_strength = 2'(s);
        bus.in_num_px   = NW'(np);
        bus.in_ref      = rf;
        bus.in_edge     = ed;
        bus.out_ready   = 1'b0;
        check_int({tag, " in_ready"}, int'(bus.in_ready), 1);
        @(posedge clk); #1;
        lat = 1;
        bus.in_valid    = 1'b0;
        bus.in_edge     = ~ed;
        bus.in_ref      = ~rf;
        bus.in_strength = 2'(s + 1);
        bus.in_num_px   = '0;
        check_int({tag, " busy"}, int'(busy), 1);
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        x = sb.pop_front();
        check_int({tag, " latency"}, lat, x.lat);
        check_vec({tag, " out_edge"}, bus.out_edge, x.edge_v);
        check_int({tag, " out_num_px"}, int'(bus.out_num_px), x.npx);
        got = bus.out_edge;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_int({tag, " hold valid"}, int'(bus.out_valid), 1);
            check_int({tag, " hold in_ready"}, int'(bus.in_ready), 0);
            check_int({tag, " hold busy"}, int'(busy), 1);
            check_vec({tag, " hold edge"}, bus.out_edge, x.edge_v);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_int({tag, " back idle"}, int'(bus.in_ready), 1);
        check_int({tag, " valid drop"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        logic [W-1:0] ed;
        logic [W-1:0] got;
        logic [W-1:0] flat;
        int           imp [8];

        bus.in_valid    = 1'b0;
        bus.in_strength = '0;
        bus.in_num_px   = '0;
        bus.in_ref      = '0;
        bus.in_edge     = '0;
        bus.out_ready   = 1'b0;
        #12;
        check_int("rst in_ready", int'(bus.in_ready), 1);
        check_int("rst out_valid", int'(bus.out_valid), 0);
        check_int("rst busy", int'(busy), 0);
        check_vec("rst out_edge", bus.out_edge, '0);
        check_int("rst out_num_px", int'(bus.out_num_px), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Flat edge stays flat.
        for (int n = 0; n < MS * CH; n++) flat[n*BD +: BD] = BD'(100);
        run_txn("flat", 1, 8, {CH{BD'(100)}}, flat, 0, got);
        check_vec("flat const", got, flat);

        // Ramp: interior follows the ramp, the far end sees the replicated last sample.
        ed = '0;
        for (int n = 0; n < MS; n++)
            for (int c = 0; c < CH; c++) ed[n*SW + c*BD +: BD] = (n < 8) ? BD'(16 * (n + 1)) : BD'(7);
        run_txn("ramp", 1, 8, '0, ed, 0, got);
        check_int("ramp out0", int'(got[0 +: BD]), 16);
        check_int("ramp out7", int'(got[7*SW +: BD]), 124);
        check_int("ramp lane8", int'(got[8*SW + 2*BD +: BD]), 7);

        // Impulse through the strength-3 kernel.
        ed = '0;
        for (int c = 0; c < CH; c++) ed[3*SW + c*BD +: BD] = BD'(160);
        imp = '{0, 20, 40, 40, 40, 20, 0, 0};
        run_txn("impulse", 3, 8, '0, ed, 0, got);
        for (int n = 0; n < 8; n++) begin
            check_int($sformatf("impulse lane%0d", n), int'(got[n*SW + BD +: BD]), imp[n]);
        end

        // Bypass returns the input untouched at minimum latency.
        ed = rand_edge();
        run_txn("bypass", 0, 8, SW'($urandom), ed, 0, got);
        check_vec("bypass eq in", got, ed);

        // Partial edge: lanes past num_px pass through.
        ed = rand_edge();
        run_txn("partial", 2, 4, SW'($urandom), ed, 0, got);
        check_vec("partial upper", got >> (4 * SW), ed >> (4 * SW));

        // Backpressure with output held for 5 cycles.
        run_txn("backpr", 2, 5, SW'($urandom), rand_edge(), 5, got);

        // Oversized num_px is clamped; num_px=0 bypasses even with a nonzero strength.
        run_txn("clamp", 3, 20, SW'($urandom), rand_edge(), 0, got);
        ed = rand_edge();
        run_txn("npx0", 3, 0, SW'($urandom), ed, 0, got);
        check_vec("npx0 eq in", got, ed);

        // Reset in the middle of filtering aborts without a partial result.
        bus.in_valid    = 1'b1;
        bus.in_strength = 2'd1;
        bus.in_num_px   = NW'(8);
        bus.in_ref      = SW'($urandom);
        bus.in_edge     = rand_edge();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_int("midrst busy before", int'(busy), 1);
        rst_n = 1'b0;
        #2;
        check_int("midrst out_valid", int'(bus.out_valid), 0);
        check_int("midrst in_ready", int'(bus.in_ready), 1);
        check_int("midrst busy", int'(busy), 0);
        check_int("midrst out_num_px", int'(bus.out_num_px), 0);
        check_vec("midrst out_edge", bus.out_edge, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_int("postrst in_ready", int'(bus.in_ready), 1);
        repeat (2) begin
            @(posedge clk); #1;
            check_int("postrst out_valid", int'(bus.out_valid), 0);
        end
        run_txn("after rst", 3, 16, SW'($urandom), rand_edge(), 1, got);
        run_txn("rand s1", 1, 11, SW'($urandom), rand_edge(), 0, got);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
